// File: rtl/integral_image_gen_if.sv
// Handshake bundle for integral_image_gen.
//   master : frame control (start/width/height), pixel source (pix_valid/pix_data),
//            result sink ready (sum_ready); observes status (busy/done/err).
//   slave  : the generator; returns pix_ready and drives the result stream
//            (sum_valid/sum_data/sum_addr) plus status.
interface integral_image_gen_if #(
  parameter int SUM_W = 32
);
  logic              start;
  logic [15:0]       width;
  logic [15:0]       height;
  logic              pix_valid;
  logic [7:0]        pix_data;
  logic              pix_ready;
  logic              sum_valid;
  logic [SUM_W-1:0]  sum_data;
  logic [31:0]       sum_addr;
  logic              sum_ready;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, width, height, pix_valid, pix_data, sum_ready,
    input  pix_ready, sum_valid, sum_data, sum_addr, busy, done, err
  );

  modport slave (
    input  start, width, height, pix_valid, pix_data, sum_ready,
    output pix_ready, sum_valid, sum_data, sum_addr, busy, done, err
  );
endinterface

// File: rtl/integral_image_gen.sv
// Streaming summed-area-table generator.
// Accepts 8-bit pixels of a width x height tile in raster order and emits the
// inclusive integral image ii(x,y) one word per pixel, tagged with its linear
// address row*width+col, one cycle after each pixel is accepted.
// Ports:
//   clk, reset : clock; asynchronous active-high reset
//   bus        : integral_image_gen_if.slave (start/width/height, pixel stream in,
//                sum stream out, busy/done/err status)
module integral_image_gen #(
  parameter int MAX_WIDTH = 1024,
  parameter int SUM_W     = 32
) (
  input logic                 clk,
  input logic                 reset,
  integral_image_gen_if.slave bus
);
  localparam int          IDX_W   = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam logic [16:0] MAX_W17 = 17'(MAX_WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t           state;
  logic [15:0]      w_lat;
  logic [15:0]      h_lat;
  logic [15:0]      col;
  logic [15:0]      row;
  logic [31:0]      addr;
  logic [SUM_W-1:0] row_acc;
  logic [SUM_W-1:0] sum_p1;
  logic [31:0]      addr_p1;
  logic             vld_p1;
  logic             done_q;
  logic             err_q;

  // Previous-row integral values, one per column. Never reset: row 0 masks it.
  logic [SUM_W-1:0] linebuf [MAX_WIDTH];

  logic             accept;
  logic             hshake;
  logic             last_pix;
  logic             end_col;
  logic [SUM_W-1:0] above;
  logic [SUM_W-1:0] row_acc_n;
  logic [SUM_W-1:0] sum_n;

  function automatic logic [SUM_W-1:0] zext_pix(input logic [7:0] p);
    return SUM_W'(p);
  endfunction

  assign bus.pix_ready = (state == RUN) && (!vld_p1 || bus.sum_ready);
  assign accept        = bus.pix_valid && bus.pix_ready;
  assign hshake        = vld_p1 && bus.sum_ready;
  assign end_col       = (col == w_lat - 16'd1);
  assign last_pix      = end_col && (row == h_lat - 16'd1);

  // Stage p0: combine running row sum with the value above (old line-buffer
  // contents; the write of this cycle lands at the clock edge).
  always_comb begin
    above     = (row == 16'd0) ? '0 : linebuf[col[IDX_W-1:0]];
    row_acc_n = ((col == 16'd0) ? '0 : row_acc) + zext_pix(bus.pix_data);
    sum_n     = row_acc_n + above;
  end

  always_ff @(posedge clk) begin
    if (accept) linebuf[col[IDX_W-1:0]] <= sum_n;
  end

  // Stage p1: registered result word and control FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      w_lat   <= '0;
      h_lat   <= '0;
      col     <= '0;
      row     <= '0;
      addr    <= '0;
      row_acc <= '0;
      sum_p1  <= '0;
      addr_p1 <= '0;
      vld_p1  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.width == 16'd0 || bus.height == 16'd0) begin
              err_q  <= 1'b0;
              done_q <= 1'b1;
            end else if ({1'b0, bus.width} > MAX_W17) begin
              err_q  <= 1'b1;
              done_q <= 1'b1;
            end else begin
              w_lat   <= bus.width;
              h_lat   <= bus.height;
              col     <= '0;
              row     <= '0;
              addr    <= '0;
              row_acc <= '0;
              err_q   <= 1'b0;
              state   <= RUN;
            end
          end
        end
        RUN: begin
          if (accept && last_pix) state <= FLUSH;
        end
        FLUSH: begin
          if (hshake) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        row_acc <= row_acc_n;
        sum_p1  <= sum_n;
        addr_p1 <= addr;
        addr    <= addr + 32'd1;
        vld_p1  <= 1'b1;
        if (end_col) begin
          col <= '0;
          row <= row + 16'd1;
        end else begin
          col <= col + 16'd1;
        end
      end else if (hshake) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign bus.sum_valid = vld_p1;
  assign bus.sum_data  = sum_p1;
  assign bus.sum_addr  = addr_p1;
  assign bus.busy      = (state != IDLE);
  // Empty/invalid frames report through done_q; a real frame ends on the
  // handshake of its last word, while the FSM is still in FLUSH.
  assign bus.done      = done_q || ((state == FLUSH) && hshake);
  assign bus.err       = err_q;
endmodule

// File: tb/tb_integral_image_gen.sv
module tb_integral_image_gen;
  localparam int MAXW = 1024;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  integral_image_gen_if #(.SUM_W(32)) bus ();

  integral_image_gen #(.MAX_WIDTH(MAXW), .SUM_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          w;
    int          h;
    int          pat;      // 0 all ones, 1 all 255, 2 ramp 1..N, 3 random
    int          rdy;      // sum_ready percentage
    int          vld;      // pix_valid percentage
    bit          inj;      // pulse start mid-frame
    logic [31:0] exp_last; // 0 = taken from the model only
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
  } exp_t;

  exp_t        sbq[$];
  int          img[0:1023];
  int          sat[0:1023];
  logic [31:0] got[0:1023];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [63:0] g, input logic [63:0] e);
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, g, e);
    end
  endtask

  // Software SAT by inclusion-exclusion.
  task automatic build(input int w, input int h, input int pat);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        int k;
        int s;
        k = y * w + x;
        case (pat)
          0: img[k] = 1;
          1: img[k] = 255;
          2: img[k] = (k % 255) + 1;
          default: img[k] = int'($urandom_range(255));
        endcase
        s = img[k];
        if (x > 0) s += sat[k - 1];
        if (y > 0) s += sat[k - w];
        if (x > 0 && y > 0) s -= sat[k - w - 1];
        sat[k] = s;
      end
  endtask

  // Entered and left at posedge+1.
  task automatic run_frame(input int w, input int h, input int pat, input int rdy,
                           input int vld, input bit inj, output int dur);
    int idx, outs, first_acc, done_cyc;
    bit done_seen, prev_stall;
    logic [31:0] pd, pa;
    exp_t e;
    build(w, h, pat);
    sbq.delete();
    bus.start = 1'b1; bus.width = 16'(w); bus.height = 16'(h);
    @(posedge clk); #1;
    bus.start = 1'b0;
    idx = 0; outs = 0; first_acc = -1; done_cyc = -1;
    done_seen = 1'b0; prev_stall = 1'b0; pd = '0; pa = '0;
    for (int cyc = 0; cyc < 20000 && !done_seen; cyc++) begin
      bus.pix_valid = (idx < w * h) && (int'($urandom_range(99)) < vld);
      bus.pix_data  = bus.pix_valid ? 8'(img[idx]) : 8'(int'($urandom_range(255)));
      bus.sum_ready = int'($urandom_range(99)) < rdy;
      bus.start     = inj && (cyc == 3);
      if (inj && cyc == 3) begin bus.width = 16'd2; bus.height = 16'd2; end
      @(negedge clk);
      if (cyc == 0) chk("busy_run", 64'(bus.busy), 64'd1);
      if (prev_stall) begin
        chk("stall_data", 64'(bus.sum_data), 64'(pd));
        chk("stall_addr", 64'(bus.sum_addr), 64'(pa));
      end
      prev_stall = bus.sum_valid && !bus.sum_ready;
      if (prev_stall) begin
        chk("stall_pix_ready", 64'(bus.pix_ready), 64'd0);
        pd = bus.sum_data; pa = bus.sum_addr;
      end
      if (bus.sum_valid && bus.sum_ready) begin
        if (sbq.size() == 0) begin
          chk("sb_empty", 64'(sbq.size()), 64'd1);
        end else begin
          e = sbq.pop_front();
          chk("sum_data", 64'(bus.sum_data), 64'(e.data));
          chk("sum_addr", 64'(bus.sum_addr), 64'(e.addr));
        end
        if (outs < 1024) got[outs] = bus.sum_data;
        outs++;
        chk("done_at_hs", 64'(bus.done), 64'(outs == w * h));
        if (bus.done) begin
          chk("busy_done", 64'(bus.busy), 64'd1);
          done_seen = 1'b1; done_cyc = cyc;
        end
      end else begin
        chk("done_quiet", 64'(bus.done), 64'd0);
      end
      if (bus.pix_valid && bus.pix_ready) begin
        e.data = 32'(sat[idx]); e.addr = 32'(idx);
        sbq.push_back(e);
        if (first_acc < 0) first_acc = cyc;
        idx++;
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0; bus.pix_valid = 1'b0;
    chk("frame_done_seen", 64'(done_seen), 64'd1);
    chk("frame_outs", 64'(outs), 64'(w * h));
    chk("frame_sb_left", 64'(sbq.size()), 64'd0);
    chk("busy_after", 64'(bus.busy), 64'd0);
    chk("err_after", 64'(bus.err), 64'd0);
    dur = done_cyc - first_acc + 1;
  endtask

  task automatic bad_start(input int w, input int h, input logic exp_err);
    bus.start = 1'b1; bus.width = 16'(w); bus.height = 16'(h);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("bad_done", 64'(bus.done), 64'd1);
    chk("bad_err", 64'(bus.err), 64'(exp_err));
    chk("bad_sum_valid", 64'(bus.sum_valid), 64'd0);
    chk("bad_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    chk("bad_done_clear", 64'(bus.done), 64'd0);
    chk("bad_err_hold", 64'(bus.err), 64'(exp_err));
    chk("bad_sum_valid2", 64'(bus.sum_valid), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t vecs[7];
    int   c33[9];
    int   c22[4];
    int   dur;
    c33 = '{1, 2, 3, 2, 4, 6, 3, 6, 9};
    c22 = '{1, 3, 4, 10};
    vecs[0] = '{3, 3, 0, 100, 100, 1'b0, 32'd9};
    vecs[1] = '{4, 4, 1, 100, 100, 1'b0, 32'd4080};
    vecs[2] = '{2, 2, 2, 100, 100, 1'b0, 32'd10};
    vecs[3] = '{24, 24, 3, 50, 100, 1'b0, 32'd0};
    vecs[4] = '{5, 4, 3, 60, 70, 1'b1, 32'd0};
    vecs[5] = '{1, 5, 2, 100, 100, 1'b0, 32'd15};
    vecs[6] = '{7, 1, 2, 100, 100, 1'b0, 32'd28};

    bus.start = 1'b0; bus.width = '0; bus.height = '0;
    bus.pix_valid = 1'b0; bus.pix_data = '0; bus.sum_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_pix_ready", 64'(bus.pix_ready), 64'd0);
    chk("rst_sum_valid", 64'(bus.sum_valid), 64'd0);
    chk("rst_sum_data", 64'(bus.sum_data), 64'd0);
    chk("rst_sum_addr", 64'(bus.sum_addr), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    bad_start(0, 5, 1'b0);
    bad_start(MAXW + 1, 3, 1'b1);

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i].w, vecs[i].h, vecs[i].pat, vecs[i].rdy, vecs[i].vld,
                vecs[i].inj, dur);
      if (vecs[i].exp_last != 0)
        chk("last_word", 64'(got[vecs[i].w * vecs[i].h - 1]), 64'(vecs[i].exp_last));
      if (vecs[i].rdy == 100 && vecs[i].vld == 100)
        chk("frame_cycles", 64'(dur), 64'(vecs[i].w * vecs[i].h + 1));
      if (i == 2)
        for (int k = 0; k < 4; k++) chk("seq_2x2", 64'(got[k]), 64'(c22[k]));
    end

    // Reset in the middle of a 6x6 frame, then a clean 3x3 frame.
    bus.start = 1'b1; bus.width = 16'd6; bus.height = 16'd6;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.pix_valid = 1'b1; bus.sum_ready = 1'b1;
    repeat (5) begin
      bus.pix_data = 8'd7;
      @(posedge clk); #1;
    end
    bus.pix_valid = 1'b0;
    chk("mid_busy", 64'(bus.busy), 64'd1);
    chk("mid_sum_valid", 64'(bus.sum_valid), 64'd1);
    reset = 1'b1;
    #1;
    chk("arst_sum_valid", 64'(bus.sum_valid), 64'd0);
    chk("arst_sum_data", 64'(bus.sum_data), 64'd0);
    chk("arst_sum_addr", 64'(bus.sum_addr), 64'd0);
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_pix_ready", 64'(bus.pix_ready), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_frame(3, 3, 0, 100, 100, 1'b0, dur);
    for (int k = 0; k < 9; k++) chk("seq_3x3_after_rst", 64'(got[k]), 64'(c33[k]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
